// File: rtl/lfsr_stim_pkg.sv
// Shared types, defaults and the Galois step function for the LFSR
// stimulus generator.
package lfsr_stim_pkg;

    // Widest LFSR the step function supports; narrower registers are
    // zero-extended in and truncated back out.
    localparam int MAX_W = 32;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shift Galois form.
    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Burst controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // One Galois step: shift right, fold taps in when the bit leaving
    // the register is 1. Zero upper bits in both arguments stay zero,
    // so the result is valid for any width up to MAX_W.
    function automatic logic [MAX_W-1:0] galois_next(
        input logic [MAX_W-1:0] s,
        input logic [MAX_W-1:0] taps
    );
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/lfsr_stim_gen_if.sv
// Output word stream of the stimulus generator.
//
// Handshake: a word transfers on every rising clock edge where both
// out_valid and out_ready are high. Once out_valid is raised, it and
// out_data stay stable until that transfer happens (no retraction);
// out_ready may change freely and does not depend on out_valid.
interface lfsr_stim_gen_if #(
    parameter int WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Generator side.
    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    // Downstream capture side.
    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/lfsr_galois.sv
// Galois LFSR state register with seed load, handshake-driven advance
// and a guard that never lets an all-zero seed lock the register up.
module lfsr_galois
    import lfsr_stim_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             advance,
    output logic [WIDTH-1:0] lfsr_state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] safe_seed;

    // Next value of the sequence from the current register contents.
    assign step_value = WIDTH'(galois_next(MAX_W'(state_q), MAX_W'(TAPS)));

    // An all-zero state is a fixed point of the LFSR; substitute SEED.
    assign safe_seed = (load_value == '0) ? SEED : load_value;

    // State register: load has priority over advance; the controller
    // only asserts them in mutually exclusive states anyway.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= SEED;
        end else if (load) begin
            state_q <= safe_seed;
        end else if (advance) begin
            state_q <= step_value;
        end
    end

    assign lfsr_state = state_q;

endmodule

// File: rtl/lfsr_stim_gen.sv
// Burst controller for the LFSR stimulus source. Emits burst_len words
// of the Galois sequence over a valid/ready stream, pulses done at the
// end of each burst, and keeps the sequence running across bursts.
module lfsr_stim_gen
    import lfsr_stim_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
    parameter int               LEN_W = 8
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed_in,
    lfsr_stim_gen_if.master   out_if,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  word_cnt,
    output state_t            dbg_state
);

    state_t           state_q;
    logic             valid_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] next_cnt;
    logic             handshake;
    logic             last_word;
    logic             seed_load_en;
    logic [WIDTH-1:0] lfsr_q;

    // valid_q is only ever high in RUN, so a handshake implies RUN.
    assign handshake    = valid_q && out_if.out_ready;

    // len_q >= 1 whenever RUN is entered, so next_cnt never has to wrap
    // past len_q: the burst stops at the latched length, at most 2^LEN_W-1.
    assign next_cnt     = word_cnt + LEN_W'(1);
    assign last_word    = (next_cnt == len_q);

    // Reseeding is only allowed between bursts.
    assign seed_load_en = (state_q == IDLE) && seed_load;

    lfsr_galois #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .CK         (CK),
        .RN         (RN),
        .load       (seed_load_en),
        .load_value (seed_in),
        .advance    (handshake),
        .lfsr_state (lfsr_q)
    );

    // Burst FSM with registered valid/busy/done/word count.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_cnt <= '0;
            len_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q    <= burst_len;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        if (burst_len != '0) begin
                            state_q <= RUN;
                            valid_q <= 1'b1;
                        end else begin
                            // Empty burst: skip straight to the done pulse.
                            state_q <= DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        word_cnt <= next_cnt;
                        if (last_word) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = lfsr_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_lfsr_stim_gen.sv
// Directed bench for lfsr_stim_gen. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point, so the values seen
// reflect that edge and the inputs set will be captured by the next one.
module tb_lfsr_stim_gen;
    import lfsr_stim_pkg::*;

    localparam int WIDTH = 16;
    localparam int LEN_W = 8;

    logic             CK;
    logic             RN;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] word_cnt;
    state_t           dbg_state;

    int errors = 0;
    int checks = 0;

    lfsr_stim_gen_if #(.WIDTH(WIDTH)) out_if ();

    lfsr_stim_gen #(
        .WIDTH (WIDTH),
        .TAPS  (16'hB400),
        .SEED  (16'hACE1),
        .LEN_W (LEN_W)
    ) dut (
        .CK        (CK),
        .RN        (RN),
        .start     (start),
        .burst_len (burst_len),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_if    (out_if),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt),
        .dbg_state (dbg_state)
    );

    // Clock
    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        RN               = 1'b0;
        start            = 1'b0;
        burst_len        = '0;
        seed_load        = 1'b0;
        seed_in          = '0;
        out_if.out_ready = 1'b0;
        repeat (2) @(posedge CK);
        @(negedge CK);
        RN = 1'b1;
        tick();
    endtask

    // Accept a start at the next edge; returns just after that edge.
    task automatic start_burst(input logic [LEN_W-1:0] len);
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        RN = 1'b0; start = 1'b0; burst_len = '0; seed_load = 1'b0; seed_in = '0;
        out_if.out_ready = 1'b0;
        #13;
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_if.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
        checks++; if (out_if.out_data !== 16'hACE1) begin errors++; $display("FAIL reset_data: got %h want ace1", out_if.out_data); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        @(negedge CK);
        RN = 1'b1;
        tick();
    endtask

    task automatic test_basic_burst();
        do_reset();
        out_if.out_ready = 1'b1;
        start_burst(8'd3);
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'hACE1) begin errors++; $display("FAIL basic_w0: valid=%b data=%h want 1/ace1", out_if.out_valid, out_if.out_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        tick();
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'hE270) begin errors++; $display("FAIL basic_w1: valid=%b data=%h want 1/e270", out_if.out_valid, out_if.out_data); end
        tick();
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'h7138) begin errors++; $display("FAIL basic_w2: valid=%b data=%h want 1/7138", out_if.out_valid, out_if.out_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_early_done: got %b want 0", done); end
        tick();
        checks++; if (out_if.out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_done_cycle: valid=%b done=%b busy=%b want 0/1/1", out_if.out_valid, done, busy); end
        checks++; if (word_cnt !== 8'd3) begin errors++; $display("FAIL basic_word_cnt: got %0d want 3", word_cnt); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL basic_after_done: done=%b busy=%b state=%0d want 0/0/IDLE", done, busy, dbg_state); end
        checks++; if (word_cnt !== 8'd3) begin errors++; $display("FAIL basic_cnt_hold: got %0d want 3", word_cnt); end
        checks++; if (out_if.out_data !== 16'h389C) begin errors++; $display("FAIL basic_next_state: got %h want 389c", out_if.out_data); end
    endtask

    // Second burst without reseeding continues the sequence.
    task automatic test_back_to_back();
        start_burst(8'd2);
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'h389C) begin errors++; $display("FAIL b2b_w0: valid=%b data=%h want 1/389c", out_if.out_valid, out_if.out_data); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL b2b_cnt_clear: got %0d want 0", word_cnt); end
        tick();
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'h1C4E) begin errors++; $display("FAIL b2b_w1: valid=%b data=%h want 1/1c4e", out_if.out_valid, out_if.out_data); end
        tick();
        checks++; if (done !== 1'b1 || word_cnt !== 8'd2) begin errors++; $display("FAIL b2b_done: done=%b cnt=%0d want 1/2", done, word_cnt); end
        tick();
    endtask

    task automatic test_stall();
        int extra;
        do_reset();
        out_if.out_ready = 1'b0;
        start_burst(8'd2);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'hACE1) begin errors++; $display("FAIL stall_hold%0d: valid=%b data=%h want 1/ace1", i, out_if.out_valid, out_if.out_data); end
            tick();
        end
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'hACE1 || word_cnt !== 8'd0) begin errors++; $display("FAIL stall_end: valid=%b data=%h cnt=%0d want 1/ace1/0", out_if.out_valid, out_if.out_data, word_cnt); end
        out_if.out_ready = 1'b1;
        tick();
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'hE270 || word_cnt !== 8'd1) begin errors++; $display("FAIL stall_w1: valid=%b data=%h cnt=%0d want 1/e270/1", out_if.out_valid, out_if.out_data, word_cnt); end
        tick();
        checks++; if (out_if.out_valid !== 1'b0 || done !== 1'b1 || word_cnt !== 8'd2) begin errors++; $display("FAIL stall_done: valid=%b done=%b cnt=%0d want 0/1/2", out_if.out_valid, done, word_cnt); end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_if.out_valid === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL stall_extra_words: got %0d want 0", extra); end
    endtask

    task automatic test_seed();
        do_reset();
        out_if.out_ready = 1'b1;
        start_burst(8'd1);
        tick();
        tick();
        checks++; if (out_if.out_data !== 16'hE270) begin errors++; $display("FAIL seed_pre: got %h want e270", out_if.out_data); end
        // Zero seed must fall back to SEED.
        seed_load = 1'b1; seed_in = 16'h0000;
        tick();
        seed_load = 1'b0;
        checks++; if (out_if.out_data !== 16'hACE1) begin errors++; $display("FAIL seed_zero_guard: got %h want ace1", out_if.out_data); end
        start_burst(8'd1);
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'hACE1) begin errors++; $display("FAIL seed_zero_word: valid=%b data=%h want 1/ace1", out_if.out_valid, out_if.out_data); end
        tick();
        tick();
        // Seed load and start in the same cycle: burst uses the new seed.
        seed_load = 1'b1; seed_in = 16'h0001;
        start_burst(8'd1);
        seed_load = 1'b0;
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'h0001) begin errors++; $display("FAIL seed_one_word: valid=%b data=%h want 1/0001", out_if.out_valid, out_if.out_data); end
        tick();
        checks++; if (done !== 1'b1 || out_if.out_data !== 16'hB400) begin errors++; $display("FAIL seed_one_next: done=%b data=%h want 1/b400", done, out_if.out_data); end
        tick();
    endtask

    task automatic test_zero_len();
        do_reset();
        out_if.out_ready = 1'b1;
        start_burst(8'd0);
        checks++; if (out_if.out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero_done: valid=%b done=%b busy=%b want 0/1/1", out_if.out_valid, done, busy); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL zero_cnt: got %0d want 0", word_cnt); end
        tick();
        checks++; if (out_if.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after: valid=%b done=%b busy=%b want 0/0/0", out_if.out_valid, done, busy); end
        checks++; if (out_if.out_data !== 16'hACE1) begin errors++; $display("FAIL zero_data: got %h want ace1", out_if.out_data); end
    endtask

    task automatic test_abort();
        int done_seen;
        do_reset();
        out_if.out_ready = 1'b1;
        start_burst(8'd5);
        tick();
        tick();
        checks++; if (word_cnt !== 8'd2 || out_if.out_data !== 16'h7138) begin errors++; $display("FAIL abort_pre: cnt=%0d data=%h want 2/7138", word_cnt, out_if.out_data); end
        #2;
        RN = 1'b0;
        #1;
        checks++; if (out_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || word_cnt !== 8'd0) begin errors++; $display("FAIL abort_async: valid=%b busy=%b done=%b cnt=%0d want 0/0/0/0", out_if.out_valid, busy, done, word_cnt); end
        checks++; if (out_if.out_data !== 16'hACE1) begin errors++; $display("FAIL abort_data: got %h want ace1", out_if.out_data); end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        @(negedge CK);
        RN = 1'b1;
        tick();
        if (done === 1'b1) done_seen++;
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
        start_burst(8'd1);
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'hACE1) begin errors++; $display("FAIL abort_restart: valid=%b data=%h want 1/ace1", out_if.out_valid, out_if.out_data); end
        tick();
        tick();
    endtask

    task automatic test_run_ignores();
        do_reset();
        out_if.out_ready = 1'b1;
        start_burst(8'd3);
        start = 1'b1; burst_len = 8'd7; seed_load = 1'b1; seed_in = 16'h1234;
        tick();
        start = 1'b0; seed_load = 1'b0;
        checks++; if (out_if.out_data !== 16'hE270) begin errors++; $display("FAIL ignore_w1: got %h want e270", out_if.out_data); end
        tick();
        checks++; if (out_if.out_data !== 16'h7138) begin errors++; $display("FAIL ignore_w2: got %h want 7138", out_if.out_data); end
        tick();
        checks++; if (done !== 1'b1 || word_cnt !== 8'd3 || out_if.out_data !== 16'h389C) begin errors++; $display("FAIL ignore_done: done=%b cnt=%0d data=%h want 1/3/389c", done, word_cnt, out_if.out_data); end
        tick();
    endtask

    task automatic test_max_len();
        int n_valid;
        int seen_done;
        do_reset();
        out_if.out_ready = 1'b1;
        start_burst(8'd255);
        n_valid = 0;
        seen_done = 0;
        for (int i = 0; i < 300 && seen_done == 0; i++) begin
            if (out_if.out_valid === 1'b1) n_valid++;
            if (done === 1'b1) seen_done = 1;
            else tick();
        end
        checks++; if (seen_done !== 1) begin errors++; $display("FAIL max_timeout: no done within 300 cycles"); end
        checks++; if (n_valid !== 255 || word_cnt !== 8'd255) begin errors++; $display("FAIL max_count: words=%0d cnt=%0d want 255/255", n_valid, word_cnt); end
        tick();
        checks++; if (word_cnt !== 8'd255 || busy !== 1'b0) begin errors++; $display("FAIL max_hold: cnt=%0d busy=%b want 255/0", word_cnt, busy); end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_back_to_back();
        test_stall();
        test_seed();
        test_zero_len();
        test_abort();
        test_run_ignores();
        test_max_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
